// File: rtl/gpio_modport_if.sv
// ----------------------------------------------------------------------------
// gpio_modport_if
//
// Purpose:
//   Pin bundle between the GPIO agent and the gpio_modport target block.
//   Signal names are taken from the target's point of view:
//     gpio_i : WIDTH pins driven by the agent, read by the target
//     gpio_o : WIDTH pins driven by the target, read by the agent
//
// Modports:
//   master : the agent side   (drives gpio_i, reads gpio_o)
//   slave  : the target side  (reads gpio_i, drives gpio_o)
// ----------------------------------------------------------------------------
interface gpio_modport_if #(
    parameter int WIDTH = 1024
);
    logic [WIDTH-1:0] gpio_i;
    logic [WIDTH-1:0] gpio_o;

    modport master (
        output gpio_i,
        input  gpio_o
    );

    modport slave (
        input  gpio_i,
        output gpio_o
    );
endinterface : gpio_modport_if

// File: rtl/gpio_modport.sv
// ----------------------------------------------------------------------------
// gpio_modport
//
// Purpose:
//   Pin-level GPIO target. Decodes a small command word from the agent's
//   pins, keeps a DW-bit data register and a 16-bit command counter, and
//   reflects them, a parity bit, an ack strobe and a one-cycle loopback of
//   the unused upper pins back to the agent.
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous, active-high reset (clears every output bit)
//   bus  : gpio_modport_if.slave
//            bus.gpio_i[0]          cmd_valid
//            bus.gpio_i[2:1]        op (00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE)
//            bus.gpio_i[7:3]        reserved, ignored
//            bus.gpio_i[8 +: DW]    cmd_data
//            bus.gpio_i[W-1:DW+18]  loopback source
//            bus.gpio_o[DW-1:0]     data_reg
//            bus.gpio_o[DW +: 16]   cmd_cnt
//            bus.gpio_o[DW+16]      parity of data_reg
//            bus.gpio_o[DW+17]      ack (cycle after each accepted command)
//            bus.gpio_o[W-1:DW+18]  loopback, gpio_i delayed one cycle
//
// Parameters:
//   WIDTH : bus width in each direction, WIDTH >= DW+18
//   DW    : data register width, 8..64
// ----------------------------------------------------------------------------
module gpio_modport #(
    parameter int WIDTH = 1024,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    gpio_modport_if.slave       bus
);

    localparam int CNT_W = 16;
    localparam int LB_LO = DW + 18;          // first loopback pin
    localparam int LB_W  = WIDTH - LB_LO;    // number of loopback pins

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // ------------------------------------------------------------------
    // Input field decode
    // ------------------------------------------------------------------
    logic          cmd_valid;
    logic [1:0]    op;
    logic [DW-1:0] cmd_data;
    logic [LB_W-1:0] loop_in;

    assign cmd_valid = bus.gpio_i[0];
    assign op        = bus.gpio_i[2:1];
    assign cmd_data  = bus.gpio_i[8 +: DW];
    assign loop_in   = bus.gpio_i[WIDTH-1:LB_LO];

    // Reserved pins and the gap between cmd_data and the loopback field
    // carry no function; they are gathered here so the intent is explicit.
    logic unused_pins;
    assign unused_pins = ^{bus.gpio_i[7:3], bus.gpio_i[LB_LO-1:8+DW]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0]    data_reg;
    logic [DW-1:0]    data_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             parity_reg;
    logic             ack_reg;
    logic [LB_W-1:0]  loop_reg;

    // Next data value for the command currently on the pins. Only used when
    // cmd_valid is high, so op/cmd_data being X on idle cycles is harmless.
    always_comb begin
        data_next = data_reg;
        unique case (op)
            OP_LOAD:   data_next = cmd_data;
            OP_SET:    data_next = data_reg | cmd_data;
            OP_CLEAR:  data_next = data_reg & ~cmd_data;
            OP_TOGGLE: data_next = data_reg ^ cmd_data;
            default:   data_next = data_reg;
        endcase
    end

    // Parity is registered alongside data_reg from the same next value, so it
    // always matches the XOR of data_reg in the same cycle while still leaving
    // every output pin on a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg   <= '0;
            cnt_reg    <= '0;
            parity_reg <= 1'b0;
            ack_reg    <= 1'b0;
            loop_reg   <= '0;
        end else begin
            ack_reg  <= cmd_valid;
            loop_reg <= loop_in;
            if (cmd_valid) begin
                data_reg   <= data_next;
                parity_reg <= ^data_next;
                cnt_reg    <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};  // wraps silently
            end
        end
    end

    // ------------------------------------------------------------------
    // Output field map
    // ------------------------------------------------------------------
    assign bus.gpio_o[DW-1:0]         = data_reg;
    assign bus.gpio_o[DW +: CNT_W]    = cnt_reg;
    assign bus.gpio_o[DW+16]          = parity_reg;
    assign bus.gpio_o[DW+17]          = ack_reg;
    assign bus.gpio_o[WIDTH-1:LB_LO]  = loop_reg;

endmodule : gpio_modport

// File: tb/tb_gpio_modport.sv
// ----------------------------------------------------------------------------
// tb_gpio_modport
//
// Self-checking bench for gpio_modport (WIDTH=1024, DW=32). A behavioural
// model tracks data, counter, ack and loopback from the command rules; every
// cycle's outputs are compared field by field against it, with additional
// fixed expectations for the directed scenarios.
// ----------------------------------------------------------------------------
module tb_gpio_modport;

    localparam int W  = 1024;
    localparam int DW = 32;
    localparam int LB = DW + 18;
    localparam int LB_SPLIT = LB + 512;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gpio_modport_if #(.WIDTH(W)) bus ();

    gpio_modport #(
        .WIDTH (W),
        .DW    (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [DW-1:0] m_data;
    int unsigned   m_cnt;
    logic          m_ack;
    logic [W-1:0]  m_loop;

    task automatic model_edge(input logic r, input logic [W-1:0] pins);
        logic [DW-1:0] d;
        d = pins[8 +: DW];
        if (r) begin
            m_data = '0;
            m_cnt  = 0;
            m_ack  = 1'b0;
            m_loop = '0;
        end else begin
            if (pins[0] === 1'b1) begin
                case (pins[2:1])
                    2'd0: m_data = d;
                    2'd1: m_data = m_data | d;
                    2'd2: m_data = m_data & ~d;
                    default: m_data = m_data ^ d;
                endcase
                m_cnt = (m_cnt + 1) % 65536;
                m_ack = 1'b1;
            end else begin
                m_ack = 1'b0;
            end
            m_loop = (pins >> LB) << LB;
        end
    endtask

    task automatic compare_all(input string pfx);
        int unsigned par;
        par = $countones(m_data) % 2;
        check({pfx, ".data"},    bus.gpio_o[DW-1:0],        m_data);
        check({pfx, ".cnt"},     bus.gpio_o[DW +: 16],      m_cnt[15:0]);
        check({pfx, ".parity"},  bus.gpio_o[DW+16],         par[0]);
        check({pfx, ".ack"},     bus.gpio_o[DW+17],         m_ack);
        check({pfx, ".loop_lo"}, bus.gpio_o[LB_SPLIT-1:LB], m_loop[LB_SPLIT-1:LB]);
        check({pfx, ".loop_hi"}, bus.gpio_o[W-1:LB_SPLIT],  m_loop[W-1:LB_SPLIT]);
    endtask

    // One clock: model sees the same pins the DUT samples, outputs are
    // checked 1 time unit after the edge.
    task automatic step(input string tag, input bit do_chk);
        @(posedge clk);
        model_edge(rst, bus.gpio_i);
        #1;
        if (do_chk) compare_all(tag);
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive_cmd(input logic valid, input logic [1:0] op, input logic [DW-1:0] data);
        logic [W-1:0] v;
        v = '0;
        v[0] = valid;
        v[2:1] = op;
        v[8 +: DW] = data;
        bus.gpio_i = v;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [1:0]    s2_op  [4];
    logic [DW-1:0] s2_dat [4];
    logic [DW-1:0] s2_exp [4];

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] zero_w;

        zero_w = '0;
        m_data = '0; m_cnt = 0; m_ack = 1'b0; m_loop = '0;

        // 1. Reset with random pins and cmd_valid=1
        rst = 1'b1;
        v = rand_vec(); v[0] = 1'b1;
        bus.gpio_i = v;
        for (int i = 0; i < 2; i++) begin
            step("reset", 1'b1);
            v = rand_vec(); v[0] = 1'b1;
            bus.gpio_i = v;
        end
        check("reset.all_lo", bus.gpio_o[511:0], zero_w[511:0]);
        check("reset.all_hi", bus.gpio_o[W-1:512], zero_w[W-1:512]);
        rst = 1'b0;

        // 2. LOAD / SET / CLEAR / TOGGLE back to back
        s2_op[0] = 2'd0; s2_dat[0] = 32'h0000_00F0; s2_exp[0] = 32'h0000_00F0;
        s2_op[1] = 2'd1; s2_dat[1] = 32'h0F00_0001; s2_exp[1] = 32'h0F00_00F1;
        s2_op[2] = 2'd2; s2_dat[2] = 32'h0000_00F1; s2_exp[2] = 32'h0F00_0000;
        s2_op[3] = 2'd3; s2_dat[3] = 32'hFF00_0000; s2_exp[3] = 32'hF000_0000;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(1'b1, s2_op[i], s2_dat[i]);
            step($sformatf("ops%0d", i), 1'b1);
            check($sformatf("ops%0d.fixed_data", i), bus.gpio_o[DW-1:0], s2_exp[i]);
            check($sformatf("ops%0d.fixed_ack", i), bus.gpio_o[DW+17], 1'b1);
        end
        check("ops.fixed_cnt", bus.gpio_o[DW +: 16], 16'd4);
        check("ops.fixed_parity", bus.gpio_o[DW+16], 1'b0);

        // 3. Idle hold with X on op/cmd_data
        bus.gpio_i = '0;
        bus.gpio_i[2:1] = 'x;
        bus.gpio_i[8 +: DW] = 'x;
        for (int i = 0; i < 10; i++) step("idle", 1'b1);
        check("idle.fixed_data", bus.gpio_o[DW-1:0], 32'hF000_0000);
        check("idle.fixed_cnt",  bus.gpio_o[DW +: 16], 16'd4);
        check("idle.fixed_ack",  bus.gpio_o[DW+17], 1'b0);

        // 4. Counter wrap: reset to a zero count, then 65536 LOADs of 1
        rst = 1'b1;
        bus.gpio_i = '0;
        step("wrap_rst", 1'b1);
        rst = 1'b0;
        drive_cmd(1'b1, 2'd0, 32'h1);
        for (int i = 0; i < 65536; i++) begin
            step("wrap", (i % 4096) == 0);
            if (i == 65534) check("wrap.fixed_cnt_max", bus.gpio_o[DW +: 16], 16'hFFFF);
        end
        compare_all("wrap_end");
        check("wrap.fixed_cnt",    bus.gpio_o[DW +: 16], 16'h0000);
        check("wrap.fixed_data",   bus.gpio_o[DW-1:0], 32'h1);
        check("wrap.fixed_parity", bus.gpio_o[DW+16], 1'b1);

        // 5. Walking one across the loopback pins, no commands
        for (int b = LB; b < W; b++) begin
            v = '0;
            v[b] = 1'b1;
            bus.gpio_i = v;
            step("walk", 1'b1);
        end
        bus.gpio_i = '0;
        step("walk_end", 1'b1);
        check("walk.fixed_data", bus.gpio_o[DW-1:0], 32'h1);
        check("walk.fixed_cnt",  bus.gpio_o[DW +: 16], 16'h0000);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            bus.gpio_i = rand_vec();
            step("rand", 1'b1);
        end
        rst = 1'b0;

        // 6. Reset coincident with a TOGGLE, then LOAD 0x5A
        drive_cmd(1'b1, 2'd0, 32'hDEAD_BEEF);
        step("pre6", 1'b1);
        rst = 1'b1;
        drive_cmd(1'b1, 2'd3, 32'hFFFF_FFFF);
        step("rst_mid", 1'b1);
        check("rst_mid.fixed_lo", bus.gpio_o[511:0], zero_w[511:0]);
        check("rst_mid.fixed_hi", bus.gpio_o[W-1:512], zero_w[W-1:512]);
        rst = 1'b0;
        drive_cmd(1'b1, 2'd0, 32'h0000_005A);
        step("post_rst", 1'b1);
        check("post_rst.fixed_data", bus.gpio_o[DW-1:0], 32'h5A);
        check("post_rst.fixed_cnt",  bus.gpio_o[DW +: 16], 16'd1);
        bus.gpio_i = '0;
        step("final", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gpio_modport
